// File: rtl/l3_refill_ctrl_if.sv
// ---------------------------------------------------------------------------
// l3_refill_ctrl_if
// Signal bundle between the L3 refill controller, the L3 tag/data array and
// the backing word RAM.
//   master modport : the refill controller
//   slave  modport : the environment (L3 requester + word RAM)
// Signals:
//   miss_*/victim_*  L3 miss request with optional dirty victim
//   fill_*           refilled line returned to L3 (valid/ready)
//   busy_o           controller not idle
//   re_o/raddr_o/rdata_i/read_hit_i    RAM read handshake
//   we_o/waddr_o/wdata_o/write_hit_i   RAM write handshake
// ---------------------------------------------------------------------------
interface l3_refill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              miss_valid_i;
  logic              miss_ready_o;
  logic [ADDR_W-1:0] miss_addr_i;
  logic              victim_dirty_i;
  logic [ADDR_W-1:0] victim_addr_i;
  logic [LINE_W-1:0] victim_data_i;
  logic              fill_valid_o;
  logic              fill_ready_i;
  logic [ADDR_W-1:0] fill_addr_o;
  logic [LINE_W-1:0] fill_data_o;
  logic              fill_err_o;
  logic              busy_o;
  logic              re_o;
  logic [ADDR_W-1:0] raddr_o;
  logic [LINE_W-1:0] rdata_i;
  logic              read_hit_i;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [LINE_W-1:0] wdata_o;
  logic              write_hit_i;

  modport master (
    input  miss_valid_i, miss_addr_i, victim_dirty_i, victim_addr_i,
           victim_data_i, fill_ready_i, rdata_i, read_hit_i, write_hit_i,
    output miss_ready_o, fill_valid_o, fill_addr_o, fill_data_o, fill_err_o,
           busy_o, re_o, raddr_o, we_o, waddr_o, wdata_o
  );

  modport slave (
    output miss_valid_i, miss_addr_i, victim_dirty_i, victim_addr_i,
           victim_data_i, fill_ready_i, rdata_i, read_hit_i, write_hit_i,
    input  miss_ready_o, fill_valid_o, fill_addr_o, fill_data_o, fill_err_o,
           busy_o, re_o, raddr_o, we_o, waddr_o, wdata_o
  );
endinterface

// File: rtl/l3_refill_ctrl.sv
// ---------------------------------------------------------------------------
// l3_refill_ctrl
// Miss/writeback sequencer between the L3 cache and the backing word RAM.
// Accepts one line miss (optionally with a dirty victim), writes the victim
// back, reads the missing line and hands it to L3 over a valid/ready port.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - l3_refill_ctrl_if.master: miss request, fill response, RAM
//          read/write handshakes, busy status
// ---------------------------------------------------------------------------
module l3_refill_ctrl #(
  parameter int LINE_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  l3_refill_ctrl_if.master       bus
);

  // Line-address bits: byte address without the 5 offset bits of a 32-byte line.
  localparam int LA_W = ADDR_W - 5;
  // The counter value seen during the WAIT_MAX-th wait cycle; a missing hit
  // in that cycle means the counter reaches WAIT_MAX, i.e. a timeout.
  localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_GAP_W,
    S_RD,
    S_RESP,
    S_GAP_R
  } state_t;

  state_t            state_q, state_d;
  logic [LA_W-1:0]   miss_line_q, miss_line_d;
  logic [LA_W-1:0]   vict_line_q, vict_line_d;
  logic [LINE_W-1:0] vict_data_q, vict_data_d;
  logic [LINE_W-1:0] fill_q, fill_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              timeout;

  assign timeout = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      miss_line_q <= '0;
      vict_line_q <= '0;
      vict_data_q <= '0;
      fill_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
      vict_line_q <= vict_line_d;
      vict_data_q <= vict_data_d;
      fill_q      <= fill_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_line_d = miss_line_q;
    vict_line_d = vict_line_q;
    vict_data_d = vict_data_q;
    fill_d      = fill_q;
    err_d       = err_q;
    // WB and RD are always entered from a non-waiting state, so the counter
    // is zero on entry and simply counts the cycles spent waiting.
    cnt_d       = ((state_q == S_WB) || (state_q == S_RD)) ? cnt_q + 8'd1 : 8'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.miss_valid_i) begin
          miss_line_d = bus.miss_addr_i[ADDR_W-1:5];
          vict_line_d = bus.victim_addr_i[ADDR_W-1:5];
          vict_data_d = bus.victim_data_i;
          fill_d      = '0;
          err_d       = 1'b0;
          state_d     = bus.victim_dirty_i ? S_WB : S_RD;
        end
      end
      S_WB: begin
        // A hit in the last allowed cycle still wins over the timeout.
        if (bus.write_hit_i) begin
          state_d = S_GAP_W;
        end else if (timeout) begin
          // Failed writeback: skip the refill and report an error line.
          err_d   = 1'b1;
          fill_d  = '0;
          state_d = S_RESP;
        end
      end
      S_GAP_W: begin
        state_d = S_RD;
      end
      S_RD: begin
        if (bus.read_hit_i) begin
          fill_d  = bus.rdata_i;
          state_d = S_RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          fill_d  = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.fill_ready_i) begin
          state_d = S_GAP_R;
        end
      end
      S_GAP_R: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Enables decode straight from the state register so an async reset drops
  // them immediately and they can never be high together.
  assign bus.miss_ready_o = (state_q == S_IDLE);
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.we_o         = (state_q == S_WB);
  assign bus.re_o         = (state_q == S_RD);
  // RAM is word addressed: line index times 8 words.
  assign bus.waddr_o      = {2'b00, vict_line_q, 3'b000};
  assign bus.wdata_o      = vict_data_q;
  assign bus.raddr_o      = {2'b00, miss_line_q, 3'b000};
  assign bus.fill_valid_o = (state_q == S_RESP);
  assign bus.fill_addr_o  = {miss_line_q, 5'b00000};
  assign bus.fill_data_o  = fill_q;
  assign bus.fill_err_o   = err_q & (state_q == S_RESP);

endmodule

// File: tb/tb_l3_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_l3_refill_ctrl
// Bench for l3_refill_ctrl: a behavioural word RAM answers read/write
// requests after fixed latencies; each expected fill is queued when the miss
// is issued and compared when the controller presents the fill.
// ---------------------------------------------------------------------------
module tb_l3_refill_ctrl;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 256;
  localparam int WAIT_MAX = 16;
  localparam int RD_LAT   = 9;
  localparam int WR_LAT   = 10;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
    logic         err;
  } fill_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l3_refill_ctrl_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus();

  l3_refill_ctrl #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int    checks = 0;
  int    errors = 0;
  fill_t sb[$];

  // RAM model controls and bench-injected hit pulses
  logic         rd_en = 1'b1;
  logic         wr_en = 1'b1;
  logic         tb_read_hit = 1'b0;
  logic         tb_write_hit = 1'b0;
  logic         m_read_hit = 1'b0;
  logic         m_write_hit = 1'b0;
  logic [255:0] m_rdata = '0;
  int           rd_cnt = 0;
  int           wr_cnt = 0;

  assign bus.read_hit_i  = m_read_hit | tb_read_hit;
  assign bus.write_hit_i = m_write_hit | tb_write_hit;
  assign bus.rdata_i     = m_rdata;

  // Line content of the RAM at a given word index; index 0x10 holds words 1..8.
  function automatic logic [255:0] ram_line(input logic [31:0] raddr);
    logic [255:0] l;
    logic [31:0]  base;
    base = (raddr - 32'h10) << 16;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base | 32'(i + 1);
    return l;
  endfunction

  always @(posedge clk) begin
    m_read_hit  <= 1'b0;
    m_write_hit <= 1'b0;
    if (bus.re_o && rd_en && !m_read_hit) begin
      if (rd_cnt == RD_LAT - 1) begin
        m_read_hit <= 1'b1;
        m_rdata    <= ram_line(bus.raddr_o);
        rd_cnt     <= 0;
      end else rd_cnt <= rd_cnt + 1;
    end else rd_cnt <= 0;
    if (bus.we_o && wr_en && !m_write_hit) begin
      if (wr_cnt == WR_LAT - 1) begin
        m_write_hit <= 1'b1;
        wr_cnt      <= 0;
      end else wr_cnt <= wr_cnt + 1;
    end else wr_cnt <= 0;
  end

  // Issue one miss from a negedge with the controller idle; queue its expected fill.
  task automatic drive_miss(input logic [31:0] a, input logic d, input logic [31:0] va,
                            input logic [255:0] vd, input logic exp_err);
    fill_t e;
    e.addr = a & ~32'h1F;
    e.err  = exp_err;
    e.data = exp_err ? 256'd0 : ram_line((a >> 5) << 3);
    sb.push_back(e);
    bus.miss_valid_i   = 1'b1;
    bus.miss_addr_i    = a;
    bus.victim_dirty_i = d;
    bus.victim_addr_i  = va;
    bus.victim_data_i  = vd;
    @(negedge clk);
    bus.miss_valid_i   = 1'b0;
  endtask

  task automatic wait_fill(input int budget, output bit got, output int re_cyc,
                           output int we_cyc, output int overlap);
    int n = 0;
    re_cyc = 0; we_cyc = 0; overlap = 0;
    while (!bus.fill_valid_o && n < budget) begin
      if (bus.re_o) re_cyc++;
      if (bus.we_o) we_cyc++;
      if (bus.re_o && bus.we_o) overlap++;
      @(negedge clk);
      n++;
    end
    got = bus.fill_valid_o;
  endtask

  task automatic pop_exp(output fill_t e, output bit ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
    else begin
      e.addr = '0; e.data = '0; e.err = 1'b0;
    end
    $display("fill addr=%h err=%b queued=%0d", bus.fill_addr_o, bus.fill_err_o, sb.size());
  endtask

  task automatic finish_fill();
    bus.fill_ready_i = 1'b1;
    @(negedge clk);
    bus.fill_ready_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.miss_ready_o, bus.busy_o, bus.re_o, bus.we_o, bus.fill_valid_o, bus.fill_err_o} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp 100000",
               {bus.miss_ready_o, bus.busy_o, bus.re_o, bus.we_o, bus.fill_valid_o, bus.fill_err_o});
    end
    checks++;
    if (bus.fill_data_o !== 256'd0 || bus.fill_addr_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got addr %h data %h exp 0", bus.fill_addr_o, bus.fill_data_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_miss();
    bit got; int rc, wc, ov; fill_t e; bit ok;
    drive_miss(32'h40, 1'b0, 32'h0, 256'd0, 1'b0);
    checks++;
    if (bus.re_o !== 1'b1 || bus.raddr_o !== 32'h10) begin
      errors++;
      $display("FAIL clean_raddr: got re %b raddr %h exp re 1 raddr 00000010", bus.re_o, bus.raddr_o);
    end
    wait_fill(60, got, rc, wc, ov);
    checks++;
    if (!got || wc != 0) begin
      errors++;
      $display("FAIL clean_fill_seen: got valid %b we_cycles %0d exp valid 1 we_cycles 0", got, wc);
    end
    pop_exp(e, ok);
    checks++;
    if (!ok || {bus.fill_addr_o, bus.fill_data_o, bus.fill_err_o} !== {e.addr, e.data, e.err}) begin
      errors++;
      $display("FAIL clean_fill: got %h %h %b exp %h %h %b", bus.fill_addr_o, bus.fill_data_o,
               bus.fill_err_o, e.addr, e.data, e.err);
    end
    bus.fill_ready_i = 1'b1;
    @(negedge clk);
    bus.fill_ready_i = 1'b0;
    checks++;
    if (bus.fill_valid_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.re_o !== 1'b0) begin
      errors++;
      $display("FAIL clean_gap: got valid %b busy %b re %b exp 0 1 0", bus.fill_valid_o, bus.busy_o, bus.re_o);
    end
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.miss_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL clean_idle: got busy %b ready %b exp 0 1", bus.busy_o, bus.miss_ready_o);
    end
  endtask

  task automatic test_dirty_miss();
    logic [255:0] vd = {8{32'hA5A5A5A5}};
    logic [31:0]  raddr_first = '0;
    bit seen_we = 0, seen_re = 0, re_before_we = 0, ok;
    int gap = 0, ovl = 0, wbad = 0, n = 0;
    fill_t e;
    drive_miss(32'h200, 1'b1, 32'h100, vd, 1'b0);
    while (!bus.fill_valid_o && n < 200) begin
      if (bus.re_o && bus.we_o) ovl++;
      if (bus.we_o) begin
        seen_we = 1;
        if (seen_re) re_before_we = 1;
        if (bus.waddr_o !== 32'h40 || bus.wdata_o !== vd) wbad++;
      end else if (bus.re_o) begin
        if (!seen_re) raddr_first = bus.raddr_o;
        seen_re = 1;
      end else if (seen_we && !seen_re) gap++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!seen_we || re_before_we || wbad != 0) begin
      errors++;
      $display("FAIL dirty_write: got we_seen %b re_first %b bad_cycles %0d exp 1 0 0", seen_we, re_before_we, wbad);
    end
    checks++;
    if (gap != 1) begin
      errors++;
      $display("FAIL dirty_gap: got %0d idle cycles exp 1", gap);
    end
    checks++;
    if (raddr_first !== 32'h80 || ovl != 0) begin
      errors++;
      $display("FAIL dirty_read: got raddr %h overlap %0d exp 00000080 0", raddr_first, ovl);
    end
    pop_exp(e, ok);
    checks++;
    if (!ok || {bus.fill_addr_o, bus.fill_data_o, bus.fill_err_o} !== {e.addr, e.data, e.err}) begin
      errors++;
      $display("FAIL dirty_fill: got %h %h %b exp %h %h %b", bus.fill_addr_o, bus.fill_data_o,
               bus.fill_err_o, e.addr, e.data, e.err);
    end
    finish_fill();
  endtask

  task automatic test_backpressure();
    bit got, ok; int rc, wc, ov, bad = 0, acc = 0;
    logic [255:0] d0; logic [31:0] a0; fill_t e;
    drive_miss(32'h1E0, 1'b0, 32'h0, 256'd0, 1'b0);
    wait_fill(60, got, rc, wc, ov);
    d0 = bus.fill_data_o;
    a0 = bus.fill_addr_o;
    bus.miss_valid_i = 1'b1;
    bus.miss_addr_i  = 32'h400;
    bus.victim_dirty_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.fill_valid_o || bus.fill_data_o !== d0 || bus.fill_addr_o !== a0) bad++;
      if (bus.miss_ready_o !== 1'b0) acc++;
    end
    bus.miss_valid_i = 1'b0;
    checks++;
    if (!got || bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got valid %b unstable_cycles %0d exp 1 0", got, bad);
    end
    checks++;
    if (acc != 0) begin
      errors++;
      $display("FAIL bp_no_accept: got %0d ready cycles exp 0", acc);
    end
    pop_exp(e, ok);
    checks++;
    if (!ok || {bus.fill_addr_o, bus.fill_data_o, bus.fill_err_o} !== {e.addr, e.data, e.err}) begin
      errors++;
      $display("FAIL bp_fill: got %h %h %b exp %h %h %b", bus.fill_addr_o, bus.fill_data_o,
               bus.fill_err_o, e.addr, e.data, e.err);
    end
    finish_fill();
  endtask

  task automatic test_low_bits();
    bit got, ok; int rc, wc, ov; fill_t e;
    // fill_ready held high early must not complete anything before fill_valid
    bus.fill_ready_i = 1'b1;
    drive_miss(32'h5F, 1'b0, 32'h0, 256'd0, 1'b0);
    checks++;
    if (bus.raddr_o !== 32'h10) begin
      errors++;
      $display("FAIL low_raddr: got %h exp 00000010", bus.raddr_o);
    end
    wait_fill(60, got, rc, wc, ov);
    pop_exp(e, ok);
    checks++;
    if (!got || !ok || bus.fill_addr_o !== 32'h40 ||
        {bus.fill_addr_o, bus.fill_data_o, bus.fill_err_o} !== {e.addr, e.data, e.err}) begin
      errors++;
      $display("FAIL low_fill: got %h %h %b exp %h %h %b", bus.fill_addr_o, bus.fill_data_o,
               bus.fill_err_o, e.addr, e.data, e.err);
    end
    finish_fill();
  endtask

  task automatic test_timeout();
    bit got, ok; int rc, wc, ov; fill_t e;
    rd_en = 1'b0;
    drive_miss(32'h80, 1'b0, 32'h0, 256'd0, 1'b1);
    wait_fill(100, got, rc, wc, ov);
    checks++;
    if (!got || rc != WAIT_MAX) begin
      errors++;
      $display("FAIL rd_timeout_len: got valid %b re_cycles %0d exp 1 %0d", got, rc, WAIT_MAX);
    end
    pop_exp(e, ok);
    checks++;
    if (!ok || {bus.fill_addr_o, bus.fill_data_o, bus.fill_err_o} !== {e.addr, e.data, e.err}) begin
      errors++;
      $display("FAIL rd_timeout_fill: got %h %h %b exp %h %h %b", bus.fill_addr_o, bus.fill_data_o,
               bus.fill_err_o, e.addr, e.data, e.err);
    end
    finish_fill();
    rd_en = 1'b1;
    wr_en = 1'b0;
    drive_miss(32'hC0, 1'b1, 32'h300, {8{32'h5A5A5A5A}}, 1'b1);
    wait_fill(100, got, rc, wc, ov);
    checks++;
    if (!got || rc != 0 || wc != WAIT_MAX) begin
      errors++;
      $display("FAIL wb_timeout_len: got valid %b re %0d we %0d exp 1 0 %0d", got, rc, wc, WAIT_MAX);
    end
    pop_exp(e, ok);
    checks++;
    if (!ok || {bus.fill_addr_o, bus.fill_data_o, bus.fill_err_o} !== {e.addr, e.data, e.err}) begin
      errors++;
      $display("FAIL wb_timeout_fill: got %h %h %b exp %h %h %b", bus.fill_addr_o, bus.fill_data_o,
               bus.fill_err_o, e.addr, e.data, e.err);
    end
    finish_fill();
    wr_en = 1'b1;
  endtask

  task automatic test_reset_mid_wb();
    int n = 0, wb = 0;
    wr_en = 1'b0;
    drive_miss(32'h600, 1'b1, 32'h700, {8{32'h11223344}}, 1'b0);
    while (wb < 3 && n < 20) begin
      if (bus.we_o) wb++;
      if (wb < 3) @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (wb != 3 || bus.we_o !== 1'b0 || bus.miss_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: got wb_cycles %0d we %b ready %b exp 3 0 1", wb, bus.we_o, bus.miss_ready_o);
    end
    @(negedge clk);
    rst = 1'b0;
    tb_write_hit = 1'b1;
    @(negedge clk);
    tb_write_hit = 1'b0;
    tb_read_hit  = 1'b1;
    @(negedge clk);
    tb_read_hit  = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy_o, bus.miss_ready_o, bus.we_o, bus.re_o, bus.fill_valid_o} !== 5'b01000) begin
      errors++;
      $display("FAIL rst_late_hit: got %b exp 01000",
               {bus.busy_o, bus.miss_ready_o, bus.we_o, bus.re_o, bus.fill_valid_o});
    end
    wr_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit got, ok; int rc, wc, ov; fill_t e;
    logic [31:0] a;
    logic d;
    for (int k = 0; k < 4; k++) begin
      a = $urandom & 32'h0FFF_FFFF;
      d = 1'($urandom_range(0, 1));
      drive_miss(a, d, $urandom, {8{$urandom}}, 1'b0);
      wait_fill(100, got, rc, wc, ov);
      pop_exp(e, ok);
      checks++;
      if (!got || !ok || ov != 0 ||
          {bus.fill_addr_o, bus.fill_data_o, bus.fill_err_o} !== {e.addr, e.data, e.err}) begin
        errors++;
        $display("FAIL b2b_fill%0d: got %h %h %b ovl %0d exp %h %h %b ovl 0", k, bus.fill_addr_o,
                 bus.fill_data_o, bus.fill_err_o, ov, e.addr, e.data, e.err);
      end
      finish_fill();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.miss_valid_i   = 1'b0;
    bus.miss_addr_i    = '0;
    bus.victim_dirty_i = 1'b0;
    bus.victim_addr_i  = '0;
    bus.victim_data_i  = '0;
    bus.fill_ready_i   = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_backpressure();
    test_low_bits();
    test_timeout();
    test_reset_mid_wb();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion exp completion within bound");
    $fatal(1, "watchdog expired");
  end

endmodule
